// File: rtl/watch_pkg.sv
// Shared definitions for the watch control FSM and the time/edit datapath:
// cursor encodings, digit limits and the packed time payload.
package watch_pkg;

  typedef enum logic [2:0] {
    CUR_IDLE = 3'd0,
    CUR_H10  = 3'd1,
    CUR_H1   = 3'd2,
    CUR_M10  = 3'd3,
    CUR_M1   = 3'd4
  } cursor_e;

  localparam logic [1:0] H10_MAX     = 2'd2;
  localparam logic [3:0] H1_MAX_LOW  = 4'd9;
  localparam logic [3:0] H1_MAX_HIGH = 4'd3;
  localparam logic [2:0] M10_MAX     = 3'd5;
  localparam logic [3:0] M1_MAX      = 4'd9;
  localparam logic [5:0] SEC_MAX     = 6'd59;

  typedef struct packed {
    logic [1:0] h10;
    logic [3:0] h1;
    logic [2:0] m10;
    logic [3:0] m1;
    logic [5:0] sec;
  } watch_time_t;

  // Hour-ones ceiling depends on the hour-tens digit (20-23 vs 00-19).
  function automatic logic [3:0] h1_max(input logic [1:0] h10);
    return (h10 == H10_MAX) ? H1_MAX_HIGH : H1_MAX_LOW;
  endfunction

endpackage

// File: rtl/watch_mod_counter.sv
// Generic mod-N counter with synchronous clear, enable and a combinational
// terminal-count pulse (asserted on the enabled cycle that wraps to zero).
module watch_mod_counter #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    tc_c    = en && !clear && (count_q == W'(N - 1));
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = tc_c ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/watch_time_set_datapath.sv
// HH:MM:SS timekeeping with per-digit edit, seconds tick and blink mask
// generation for the display driver.
module watch_time_set_datapath #(
  parameter int unsigned TICK_DIV  = 100000000,
  parameter int unsigned BLINK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_cursor,
  input  logic       i_blink_en,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic [1:0] o_hour_10,
  output logic [3:0] o_hour_1,
  output logic [2:0] o_min_10,
  output logic [3:0] o_min_1,
  output logic [5:0] o_sec,
  output logic       o_sec_tick,
  output logic [3:0] o_digit_blank
);

  import watch_pkg::*;

  watch_time_t tm_q, tm_d;
  logic        blink_en_q;
  logic        phase_q, phase_d;
  logic        sec_tick_q, sec_tick_d;
  logic [3:0]  blank_q, blank_d;

  logic edit_exit;
  logic cur_valid;
  logic edit_ok;
  logic tick_c;
  logic blink_tc_c;

  assign edit_exit = blink_en_q && !i_blink_en;
  assign cur_valid = i_cursor inside {CUR_H10, CUR_H1, CUR_M10, CUR_M1};
  assign edit_ok   = i_blink_en && (i_btn_up ^ i_btn_down) && cur_valid;

  // Seconds prescaler: frozen in edit, restarted from zero on edit exit.
  watch_mod_counter #(.N(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (edit_exit),
    .en    (!i_blink_en),
    .tc_c  (tick_c)
  );

  // Blink timer: restarted on every accepted edit so the new digit is seen.
  watch_mod_counter #(.N(BLINK_DIV)) u_blink_timer (
    .clk   (clk),
    .reset (reset),
    .clear (!i_blink_en || edit_ok),
    .en    (i_blink_en),
    .tc_c  (blink_tc_c)
  );

  always_comb begin
    tm_d       = tm_q;
    sec_tick_d = 1'b0;
    phase_d    = phase_q;
    blank_d    = 4'b0000;

    if (edit_exit) begin
      tm_d.sec = '0;
    end else if (tick_c) begin
      sec_tick_d = 1'b1;
      if (tm_q.sec != SEC_MAX) begin
        tm_d.sec = tm_q.sec + 6'd1;
      end else begin
        tm_d.sec = '0;
        if (tm_q.m1 != M1_MAX) begin
          tm_d.m1 = tm_q.m1 + 4'd1;
        end else begin
          tm_d.m1 = '0;
          if (tm_q.m10 != M10_MAX) begin
            tm_d.m10 = tm_q.m10 + 3'd1;
          end else begin
            tm_d.m10 = '0;
            if (tm_q.h1 != h1_max(tm_q.h10)) begin
              tm_d.h1 = tm_q.h1 + 4'd1;
            end else begin
              tm_d.h1  = '0;
              tm_d.h10 = (tm_q.h10 >= H10_MAX) ? 2'd0 : tm_q.h10 + 2'd1;
            end
          end
        end
      end
    end

    // Digit edits wrap within the digit; no carry or borrow between digits.
    if (edit_ok) begin
      case (i_cursor)
        CUR_H10: begin
          if (i_btn_up) tm_d.h10 = (tm_q.h10 >= H10_MAX) ? 2'd0 : tm_q.h10 + 2'd1;
          else          tm_d.h10 = (tm_q.h10 == 2'd0) ? H10_MAX : tm_q.h10 - 2'd1;
          if (tm_d.h10 == H10_MAX && tm_q.h1 > H1_MAX_HIGH) tm_d.h1 = H1_MAX_HIGH;
        end
        CUR_H1: begin
          if (i_btn_up) tm_d.h1 = (tm_q.h1 >= h1_max(tm_q.h10)) ? 4'd0 : tm_q.h1 + 4'd1;
          else          tm_d.h1 = (tm_q.h1 == 4'd0) ? h1_max(tm_q.h10) : tm_q.h1 - 4'd1;
        end
        CUR_M10: begin
          if (i_btn_up) tm_d.m10 = (tm_q.m10 >= M10_MAX) ? 3'd0 : tm_q.m10 + 3'd1;
          else          tm_d.m10 = (tm_q.m10 == 3'd0) ? M10_MAX : tm_q.m10 - 3'd1;
        end
        CUR_M1: begin
          if (i_btn_up) tm_d.m1 = (tm_q.m1 >= M1_MAX) ? 4'd0 : tm_q.m1 + 4'd1;
          else          tm_d.m1 = (tm_q.m1 == 4'd0) ? M1_MAX : tm_q.m1 - 4'd1;
        end
        default: ;
      endcase
    end

    if (!i_blink_en || edit_ok) begin
      phase_d = 1'b0;
    end else if (blink_tc_c) begin
      phase_d = !phase_q;
    end

    // Mask is derived from the next phase so it lines up with the new digits.
    if (i_blink_en && phase_d) begin
      case (i_cursor)
        CUR_H10: blank_d = 4'b1000;
        CUR_H1:  blank_d = 4'b0100;
        CUR_M10: blank_d = 4'b0010;
        CUR_M1:  blank_d = 4'b0001;
        default: blank_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tm_q       <= '0;
      blink_en_q <= 1'b0;
      phase_q    <= 1'b0;
      sec_tick_q <= 1'b0;
      blank_q    <= 4'b0000;
    end else begin
      tm_q       <= tm_d;
      blink_en_q <= i_blink_en;
      phase_q    <= phase_d;
      sec_tick_q <= sec_tick_d;
      blank_q    <= blank_d;
    end
  end

  assign o_hour_10     = tm_q.h10;
  assign o_hour_1      = tm_q.h1;
  assign o_min_10      = tm_q.m10;
  assign o_min_1       = tm_q.m1;
  assign o_sec         = tm_q.sec;
  assign o_sec_tick    = sec_tick_q;
  assign o_digit_blank = blank_q;

endmodule

// File: tb/tb_watch_time_set_datapath.sv
// Directed bench for watch_time_set_datapath with TICK_DIV = 4, BLINK_DIV = 3.
module tb_watch_time_set_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cursor = 3'd0;
  logic       blink_en = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;

  logic [1:0] hour_10;
  logic [3:0] hour_1;
  logic [2:0] min_10;
  logic [3:0] min_1;
  logic [5:0] sec;
  logic       sec_tick;
  logic [3:0] digit_blank;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  watch_time_set_datapath #(.TICK_DIV(4), .BLINK_DIV(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_cursor      (cursor),
    .i_blink_en    (blink_en),
    .i_btn_up      (btn_up),
    .i_btn_down    (btn_down),
    .o_hour_10     (hour_10),
    .o_hour_1      (hour_1),
    .o_min_10      (min_10),
    .o_min_1       (min_1),
    .o_sec         (sec),
    .o_sec_tick    (sec_tick),
    .o_digit_blank (digit_blank)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] c, input logic u, input logic d);
    cursor   = c;
    btn_up   = u;
    btn_down = d;
    step();
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  // HH:MM packed as a decimal number, e.g. 23:59 -> 2359.
  function automatic int hhmm();
    return int'(hour_10) * 1000 + int'(hour_1) * 100 + int'(min_10) * 10 + int'(min_1);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ticks;
    int first;
    int bad_pos;
    int blink_bad;
    int exp_blank;

    step();
    step();
    reset = 1'b0;
    check("reset_hhmm", hhmm(), 0);
    check("reset_sec", int'(sec), 0);
    check("reset_tick", int'(sec_tick), 0);
    check("reset_blank", int'(digit_blank), 0);

    // Edit to 23:59 and exercise wraps and corner inputs.
    blink_en = 1'b1;
    press(3'd1, 1'b1, 1'b0);
    press(3'd1, 1'b1, 1'b0);
    check("h10_up", hhmm(), 2000);
    repeat (3) press(3'd2, 1'b1, 1'b0);
    check("h1_up", hhmm(), 2300);
    press(3'd2, 1'b1, 1'b0);
    check("h1_wrap_up", hhmm(), 2000);
    press(3'd2, 1'b0, 1'b1);
    check("h1_wrap_down", hhmm(), 2300);
    repeat (5) press(3'd3, 1'b1, 1'b0);
    check("m10_up", hhmm(), 2350);
    press(3'd4, 1'b0, 1'b1);
    check("m1_wrap_down", hhmm(), 2359);
    press(3'd4, 1'b1, 1'b1);
    check("up_down_same", hhmm(), 2359);
    press(3'd6, 1'b1, 1'b0);
    check("cursor_6", hhmm(), 2359);

    // Exit edit and roll over through midnight.
    blink_en = 1'b0;
    cursor   = 3'd0;
    step();
    check("exit_sec", int'(sec), 0);
    check("exit_tick", int'(sec_tick), 0);
    ticks = 0; first = -1; bad_pos = 0;
    for (int i = 1; i <= 240; i++) begin
      step();
      if (sec_tick) begin
        ticks++;
        if (first < 0) first = i;
      end
      if (int'(sec_tick) != ((i % 4 == 0) ? 1 : 0)) bad_pos++;
    end
    check("first_tick", first, 4);
    check("tick_count", ticks, 60);
    check("tick_spacing", bad_pos, 0);
    check("rollover_hhmm", hhmm(), 0);
    check("rollover_sec", int'(sec), 0);

    repeat (148) step();
    check("run_sec37", int'(sec), 37);

    // Freeze in edit for 100 cycles while checking the blink cadence.
    blink_en = 1'b1;
    cursor   = 3'd2;
    check("blink_entry", int'(digit_blank), 0);
    ticks = 0; blink_bad = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (sec_tick) ticks++;
      exp_blank = ((k / 3) % 2 == 1) ? 4 : 0;
      if (k <= 12 && int'(digit_blank) != exp_blank) blink_bad++;
    end
    check("blink_cadence", blink_bad, 0);
    check("freeze_ticks", ticks, 0);
    check("freeze_sec", int'(sec), 37);
    check("blink_k100", int'(digit_blank), 4);
    press(3'd2, 1'b1, 1'b0);
    check("restart_blank0", int'(digit_blank), 0);
    check("restart_hhmm", hhmm(), 100);
    step();
    check("restart_blank1", int'(digit_blank), 0);
    step();
    check("restart_blank2", int'(digit_blank), 0);
    step();
    check("restart_blank3", int'(digit_blank), 4);
    check("edit_sec_hold", int'(sec), 37);

    // Exit clears seconds; first tick four cycles later.
    blink_en = 1'b0;
    cursor   = 3'd0;
    step();
    check("exit2_sec", int'(sec), 0);
    check("exit2_blank", int'(digit_blank), 0);
    ticks = 0;
    repeat (3) begin
      step();
      if (sec_tick) ticks++;
    end
    check("exit2_early_ticks", ticks, 0);
    step();
    check("exit2_tick", int'(sec_tick), 1);
    check("exit2_sec1", int'(sec), 1);

    // H10 clamp of H1 when moving into the 20s.
    blink_en = 1'b1;
    press(3'd1, 1'b1, 1'b0);
    check("h10_to_1", hhmm(), 1100);
    repeat (8) press(3'd2, 1'b1, 1'b0);
    check("set_19", hhmm(), 1900);
    press(3'd1, 1'b1, 1'b0);
    check("h10_clamp", hhmm(), 2300);
    press(3'd1, 1'b1, 1'b0);
    check("h10_wrap", hhmm(), 300);

    // Reset in the middle of a blanked edit.
    repeat (4) step();
    check("blink_h10", int'(digit_blank), 8);
    reset = 1'b1;
    step();
    check("midreset_hhmm", hhmm(), 0);
    check("midreset_sec", int'(sec), 0);
    check("midreset_blank", int'(digit_blank), 0);
    reset    = 1'b0;
    blink_en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/watch_time_set_datapath.md
Name: watch_time_set_datapath

Overview:
- Timekeeping and edit datapath directly downstream of the watch control FSM.
- Consumes the FSM's cursor code and blink-enable, plus debounced up/down button pulses.
- Keeps HH:MM:SS time and applies per-digit edits to the selected hour/minute digit.
- Produces BCD-split time digits and a per-digit blank mask for the display driver.

Parameters:
TICK_DIV, 100000000, clk cycles per second; the seconds prescaler modulus (>=2)
BLINK_DIV, 50000000, clk cycles per blink half-period (>=2)

Ports:
clk  input  1  system clock
reset  input  1  reset; one clock, synchronous, active-high
i_cursor  input  3  0 = idle, 1 = H10, 2 = H1, 3 = M10, 4 = M1; 5-7 treated as idle
i_blink_en  input  1  edit mode active (high whenever the FSM is not idle)
i_btn_up  input  1  single-cycle pulse: increment selected digit
i_btn_down  input  1  single-cycle pulse: decrement selected digit
o_hour_10  output  2  hour tens, 0-2
o_hour_1  output  4  hour ones, 0-9
o_min_10  output  3  minute tens, 0-5
o_min_1  output  4  minute ones, 0-9
o_sec  output  6  seconds, binary 0-59
o_sec_tick  output  1  one-cycle pulse on each seconds increment
o_digit_blank  output  4  bit3 = H10, bit2 = H1, bit1 = M10, bit0 = M1; 1 = blank that digit this cycle

Behaviour:
Reset:
- All time digits 0 (00:00:00); prescaler 0; blink counter 0 and phase 0.
- o_sec_tick = 0, o_digit_blank = 0000.
- All outputs are registered.

Run mode (i_blink_en = 0):
- Prescaler counts 0..TICK_DIV-1. At the terminal count it wraps to 0, o_sec_tick pulses high the next cycle, and seconds increment the same edge.
- Seconds 59 -> 0 carries into minutes; minutes 59 -> 00 carries into hours; 23:59:59 -> 00:00:00.
- i_btn_up and i_btn_down are ignored.

Edit mode (i_blink_en = 1):
- Prescaler and seconds are frozen; o_sec_tick = 0.
- Edit latency: an up/down pulse in cycle N updates the digit visible in cycle N+1.
- Up and down asserted in the same cycle: no change.
- Pulses with i_cursor = 0 or 5-7: no change.

Per-digit rules (no carry or borrow between digits):
- H10: range 0..2, wraps 2->0 up and 0->2 down. If the new H10 = 2 and H1 > 3, H1 is clamped to 3 in the same cycle.
- H1: max = 3 if H10 = 2, else 9; wraps max->0 up and 0->max down.
- M10: range 0..5 with wrap.
- M1: range 0..9 with wrap.

Edit exit (i_blink_en 1->0, detected against a registered copy):
- Seconds := 0 and prescaler := 0, so the first tick arrives exactly TICK_DIV cycles later.

Edit entry (0->1):
- Seconds hold their current value.

Blink:
- Counter runs only while i_blink_en = 1; each BLINK_DIV cycles the phase toggles (0 = visible, 1 = blank).
- Counter and phase reset to 0 when i_blink_en = 0, and on every accepted edit pulse, so an edited digit is shown immediately.
- o_digit_blank is one-hot for the cursor digit only when i_blink_en = 1, phase = 1 and i_cursor is 1-4; otherwise 0000.

Reset mid-edit:
- Returns to 00:00:00 with blanking cleared; the FSM is reset by the same signal.

Decomposition:
- Shared package watch_pkg holds:
  - cursor encodings CUR_IDLE/CUR_H10/CUR_H1/CUR_M10/CUR_M1 (shared with the control FSM);
  - digit limits H10_MAX = 2, H1_MAX_LOW = 9, H1_MAX_HIGH = 3, M10_MAX = 5, M1_MAX = 9, SEC_MAX = 59.
- One sub-module is natural: watch_mod_counter, a generic mod-N counter with synchronous clear, enable and terminal-count pulse. It is instantiated twice: the seconds prescaler (TICK_DIV) and the blink timer (BLINK_DIV).

Test Plan (TICK_DIV = 4, BLINK_DIV = 3):
- Rollover: edit to 23:59, exit edit, wait 60 ticks (240 cycles) -> 00:00:00; o_sec_tick exactly every 4 cycles, first pulse 4 cycles after exit.
- H10 clamp: time 19:xx, i_cursor = 1, one up pulse -> 23:xx next cycle; a second up -> 03:xx.
- Wraps without carry: i_cursor = 4, M1 = 0, down -> M1 = 9 with M10 unchanged. i_cursor = 2 with H10 = 2, H1 = 3, up -> H1 = 0.
- Blink and restart: i_cursor = 2, i_blink_en = 1 -> o_digit_blank 0000 for 3 cycles, then 0100 for 3 cycles, repeating. An up pulse during a blank phase -> 0000 next cycle and the 3-cycle visible phase restarts.
- Freeze and exit: at sec = 37, enter edit for 100 cycles -> sec stays 37 with no ticks. Exit -> sec = 0 next cycle; first tick after 4 cycles.
- Corner inputs:
  - up and down in the same cycle -> no change;
  - up with i_cursor = 6 -> no change;
  - reset asserted mid-edit -> 00:00:00 and o_digit_blank = 0000 the next cycle.
